// File: rtl/mem_if.sv
// Cache-to-memory block request interface: request held while not ready,
// completion is a one-cycle ready pulse carrying read data.
interface mem_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    // Handshake: requester raises read or write with addr/wdata and holds them
    // until the responder pulses ready for exactly one cycle; rdata is valid
    // only in that ready cycle and is not buffered anywhere.
    modport master (
        output read, write, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  read, write, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and
// D-cache miss/write-back interfaces; the granted request is latched until done.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_if.slave       i_mem,
    mem_if.slave       d_mem,
    mem_if.master      mem,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;  // 0 = I, 1 = D
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic req_i, req_d;
    logic grant_i, grant_d;
    logic serving;

    assign req_i = i_mem.read | i_mem.write;
    assign req_d = d_mem.read | d_mem.write;

    // On a tie the port that was not served last wins.
    assign grant_i = req_i & (~req_d | last_grant_q);
    assign grant_d = req_d & (~req_i | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_wr_d      = op_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d      = SERVE_I;
                    last_grant_d = 1'b0;
                    op_wr_d      = i_mem.write;
                    addr_d       = i_mem.addr;
                    wdata_d      = i_mem.wdata;
                end else if (grant_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = 1'b1;
                    op_wr_d      = d_mem.write;
                    addr_d       = d_mem.addr;
                    wdata_d      = d_mem.wdata;
                end
            end
            // Completion always passes through IDLE so the cache can drop or
            // replace its request before the next arbitration.
            SERVE_I, SERVE_D: begin
                if (mem.ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_wr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_wr_q      <= op_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

    // Request drops combinationally in the memory's ready cycle.
    assign mem.read  = serving & ~op_wr_q & ~mem.ready;
    assign mem.write = serving &  op_wr_q & ~mem.ready;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

    assign i_mem.ready = mem.ready & (state_q == SERVE_I);
    assign d_mem.ready = mem.ready & (state_q == SERVE_D);
    assign i_mem.rdata = mem.rdata;
    assign d_mem.rdata = mem.rdata;

    assign dbg_state = state_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter between the instruction cache and data cache miss/write-back interfaces and the single shared 128-bit main-memory port. Each cache sees a private, protocol-identical memory interface: request held while not ready, one-cycle ready pulse. The arbiter grants one cache at a time with round-robin fairness and latches the request so memory sees stable address, data and op until completion. Sits directly downstream of both caches and upstream of main memory.

## Interface
- ADDR_W, 28, block address width (word address minus 2 offset bits)
- DATA_W, 128, block data width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_mem_read, i_mem_write  in  1 each  I-cache request
- i_mem_addr  in  ADDR_W  I-cache block address
- i_mem_wdata  in  DATA_W  I-cache write data
- i_mem_rdata  out  DATA_W  read data to I-cache
- i_mem_ready  out  1  completion pulse to I-cache
- d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready: same for D-cache
- mem_read, mem_write  out  1  request to memory
- mem_addr  out  ADDR_W  latched block address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion pulse

## Operation
- States: IDLE, SERVE_I, SERVE_D. Registers: state, last_grant (0=I, 1=D), op_wr, addr_q, wdata_q.
- Pending: req_i = i_mem_read | i_mem_write; req_d likewise.
- IDLE: only req_i -> SERVE_I; only req_d -> SERVE_D; both -> port not equal to last_grant; none -> stay.
- On grant: latch op_wr = granted port's write (write wins if read and write both high; illegal input, defined behaviour), addr_q, wdata_q; set last_grant.
- SERVE_x: mem_read = ~op_wr & ~mem_ready; mem_write = op_wr & ~mem_ready; mem_addr = addr_q; mem_wdata = wdata_q. On mem_ready -> IDLE.
- x_mem_ready = mem_ready & (state == SERVE_x), combinational. Other port's ready held 0.
- i_mem_rdata = d_mem_rdata = mem_rdata (broadcast; qualified only by ready).
- Request drop or change by the granted cache during SERVE is ignored; latched request is completed.
- mem_ready in IDLE: ignored, no ready to either cache.
- One idle cycle after each completion is mandatory; lets the cache drop or replace its request (e.g. write-back then allocate) before re-arbitration.

## Timing
- Reset (async, immediate): state=IDLE, last_grant=1 (first tie goes to I), mem_read=mem_write=0, i/d_mem_ready=0, addr_q=wdata_q=0.
- Request visible at edge t in IDLE -> mem_read/mem_write high from cycle t+1.
- Memory ready at cycle t+k -> requester ready same cycle (combinational) -> IDLE at t+k+1 -> next grant earliest at t+k+2 memory request.
- mem_read/mem_write drop in mem_ready cycle (combinational with ~mem_ready), matching cache convention.
- Back-to-back contention alternates strictly; no port waits more than one foreign transaction.
- rst_n assert mid-SERVE: request dropped at once, no ready issued; memory sees request vanish.
- Ready and rdata same cycle; no buffering of rdata.

## Test plan
- Reset: rst_n=0 mid-SERVE_D with mem_write high -> mem_write, d_mem_ready 0 within same cycle, state IDLE; after release, idle until a request.
- Single I read: i_mem_read=1, addr 28'h000_0040; memory ready 4 cycles later with rdata 128'hDEAD..BEEF -> mem_read=1, mem_addr=0x40 one cycle after request; i_mem_ready one cycle with that rdata; d_mem_ready stays 0.
- Simultaneous after reset: I read 0x10, D write 0x20 wdata 128'h1 -> I served first, then D; mem_write=1 with mem_addr=0x20 starting 2 cycles after I's ready.
- Fairness: both ports continuously requesting for 6 transactions -> grant order I,D,I,D,I,D.
- Write-back then allocate from D: D write 0x33 completes, D immediately raises read 0x44 while I requests -> I granted (round robin), then D read 0x44; addresses never mixed.
- Robustness: granted I drops i_mem_read and changes addr to 0x99 mid-SERVE -> mem_addr stays original, mem_read stays high until mem_ready; stray mem_ready in IDLE -> no ready to either port.
